pong_ball_ctrl: RTL and testbench
=================================

# pong_ball_ctrl

Ball controller for the Pong game. Consumes both paddle Y positions produced by the paddle controllers. Moves the ball one game unit per speed tick, bounces it off the top/bottom walls and off paddles, and detects misses. On a miss it emits a one-cycle score pulse. It also generates the registered ball draw signal from the divided column/row counters, alongside the paddle draw signals.

## Interface
- c_GAME_WIDTH, 40, game columns (units)
- c_GAME_HEIGHT, 30, game rows (units)
- c_PADDLE_HEIGHT, 6, paddle occupies rows Y..Y+c_PADDLE_HEIGHT inclusive
- c_P1_PADDLE_X, 0, left paddle column
- c_P2_PADDLE_X, c_GAME_WIDTH-1, right paddle column
- c_BALL_SPEED, 1250000, tick counter terminal value; one step per c_BALL_SPEED+1 cycles
- i_Clk  in  1  system clock; single clock domain
- i_Rst_L  in  1  asynchronous, active-low reset
- i_Game_Start  in  1  level; serves the ball when in IDLE
- i_Col_Count_Div  in  6  current game column being scanned
- i_Row_Count_Div  in  6  current game row being scanned
- i_P1_Paddle_Y  in  6  left paddle top row
- i_P2_Paddle_Y  in  6  right paddle top row
- o_Draw_Ball  out  1  registered; ball occupies scanned cell
- o_Ball_X  out  6  ball column
- o_Ball_Y  out  6  ball row
- o_P1_Score_Pulse  out  1  one-cycle pulse; P2 missed
- o_P2_Score_Pulse  out  1  one-cycle pulse; P1 missed
- o_Active  out  1  high while in PLAY

## Operation
- Reset (async, i_Rst_L=0) values:
  - state IDLE.
  - Ball at (c_GAME_WIDTH/2, c_GAME_HEIGHT/2).
  - dx=right, dy=down.
  - Tick counter 0.
  - All pulse outputs, o_Draw_Ball and o_Active are 0.
- IDLE:
  - Ball held at center.
  - Counter held at 0.
  - i_Game_Start=1 → PLAY at next edge.
- PLAY:
  - Counter increments 0..c_BALL_SPEED, then wraps to 0.
  - The step is taken on the edge where counter==c_BALL_SPEED.
  - i_Game_Start is ignored.
- Vertical step, evaluated on the current Y:
  - Moving down and Y==c_GAME_HEIGHT-1 → dy flips, Y-1.
  - Moving up and Y==0 → dy flips, Y+1.
  - Otherwise Y±1.
- Horizontal step, moving left:
  - X==c_P1_PADDLE_X+1 and i_P1_Paddle_Y ≤ Y ≤ i_P1_Paddle_Y+c_PADDLE_HEIGHT → dx flips, X+1.
  - Same column, Y outside that range → miss.
  - Otherwise X-1.
- Horizontal step, moving right: mirror of the left case, using c_P2_PADDLE_X-1 and i_P2_Paddle_Y.
- Simultaneous wall bounce and paddle hit in one step: both are applied.
- Miss by P1:
  - o_P2_Score_Pulse=1 for one cycle.
  - State → IDLE, ball recentered.
  - dx=left, so the next serve goes toward P1.
  - dy unchanged.
- Miss by P2: symmetric. Pulse is o_P1_Score_Pulse; next serve dx=right.
- Width rules:
  - Paddle-range comparison is done in 7 bits, so Y+c_PADDLE_HEIGHT never wraps.
  - X/Y never leave 0..c_GAME_WIDTH-1 / 0..c_GAME_HEIGHT-1.
- Draw:
  - o_Draw_Ball <= (i_Col_Count_Div==X && i_Row_Count_Div==Y).
  - Active in both IDLE and PLAY.

## Timing
- IDLE→PLAY: one edge after i_Game_Start is sampled high. o_Active rises on that same edge.
- First step is c_BALL_SPEED+1 cycles after entering PLAY.
- Steps are then periodic every c_BALL_SPEED+1 cycles.
- o_Ball_X/Y are registered; they update on the step edge.
- Score pulse:
  - Registered; high exactly one cycle, on the same edge as the return to IDLE.
  - Never both pulses in one cycle.
- o_Draw_Ball: 1-cycle latency from the col/row inputs.
- Reset mid-PLAY: immediate return to reset values. No score pulse.

## Structure
- A shared pong constants include holds game dimensions, paddle height, paddle columns and the state encoding (IDLE, PLAY). These constants are also used by the paddle controllers and the top level.
- One sub-module, pong_tick_gen:
  - Parameterised counter with enable and async active-low reset.
  - Outputs the one-cycle o_Tick at terminal count.
  - The same generator suits the paddle speed logic.

## Test plan
All scenarios use c_BALL_SPEED=3 and default dimensions.
- Reset then start:
  - Release i_Rst_L, hold i_Game_Start=1 one cycle → o_Active=1.
  - Ball (20,15) → (21,16) after 4 cycles, then (22,17) after 4 more.
- Bottom wall: ball at (10,29) moving down-right → next step (11,28), dy=up.
- P2 paddle hit:
  - i_P2_Paddle_Y=10, ball reaches X=38, Y=16 moving right (16 = 10+6, inclusive edge).
  - Next step X=37; no score pulse.
- P1 miss:
  - i_P1_Paddle_Y=0, ball at X=1, Y=20 moving left → o_P2_Score_Pulse high exactly 1 cycle.
  - Then o_Active=0, ball (20,15), next serve moves left.
- Corner: ball at (38,0) moving up-right, paddle covering row 0 → next step (37,1). Both directions flip.
- Async reset mid-PLAY: assert i_Rst_L=0 between clock edges → outputs immediately at reset values; no score pulse.
- Draw: scan col=20, row=15 in IDLE → o_Draw_Ball=1 one cycle later, 0 for all other cells.

Source files
------------

// File: rtl/pong_ball_ctrl_pkg.sv
// Shared Pong constants: game dimensions, paddle geometry, state and direction
// encodings, plus the paddle-range helper used by the ball logic.
package pong_ball_ctrl_pkg;

    localparam int unsigned c_GAME_WIDTH    = 40;
    localparam int unsigned c_GAME_HEIGHT   = 30;
    localparam int unsigned c_PADDLE_HEIGHT = 6;
    localparam int unsigned c_P1_PADDLE_X   = 0;
    localparam int unsigned c_P2_PADDLE_X   = c_GAME_WIDTH - 1;

    localparam logic [5:0] c_CENTER_X    = 6'(c_GAME_WIDTH / 2);
    localparam logic [5:0] c_CENTER_Y    = 6'(c_GAME_HEIGHT / 2);
    localparam logic [5:0] c_Y_MAX       = 6'(c_GAME_HEIGHT - 1);
    localparam logic [5:0] c_LEFT_HIT_X  = 6'(c_P1_PADDLE_X + 1);
    localparam logic [5:0] c_RIGHT_HIT_X = 6'(c_P2_PADDLE_X - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } game_state_t;

    // DIR_NEG is left / up, DIR_POS is right / down.
    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_t;

    // Widened to 7 bits so top + paddle height cannot wrap.
    function automatic logic in_paddle_range(input logic [5:0] y, input logic [5:0] top);
        logic [6:0] y7;
        logic [6:0] top7;
        logic [6:0] bot7;
        y7   = {1'b0, y};
        top7 = {1'b0, top};
        bot7 = top7 + 7'(c_PADDLE_HEIGHT);
        return (y7 >= top7) && (y7 <= bot7);
    endfunction

endpackage

// File: rtl/pong_ball_ctrl_tick_gen.sv
// Free-running terminal-count tick generator with enable; counter clears
// whenever the enable is low.
module pong_tick_gen #(
    parameter int unsigned c_TERMINAL = 1250000,
    localparam int unsigned c_W = (c_TERMINAL > 0) ? $clog2(c_TERMINAL + 1) : 1
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_En,
    output logic o_Tick
);

    logic [c_W-1:0] count;
    logic           at_terminal;

    assign at_terminal = (count == c_W'(c_TERMINAL));
    assign o_Tick      = i_En && at_terminal;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else if (!i_En || at_terminal) begin
            count <= '0;
        end else begin
            count <= count + c_W'(1);
        end
    end

endmodule

// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: moves the ball one unit per speed tick, bounces off
// walls and paddles, detects misses and registers the ball draw signal.
module pong_ball_ctrl
    import pong_ball_ctrl_pkg::*;
#(
    parameter int unsigned c_BALL_SPEED = 1250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Game_Start,
    input  logic [5:0] i_Col_Count_Div,
    input  logic [5:0] i_Row_Count_Div,
    input  logic [5:0] i_P1_Paddle_Y,
    input  logic [5:0] i_P2_Paddle_Y,
    output logic       o_Draw_Ball,
    output logic [5:0] o_Ball_X,
    output logic [5:0] o_Ball_Y,
    output logic       o_P1_Score_Pulse,
    output logic       o_P2_Score_Pulse,
    output logic       o_Active
);

    game_state_t state, state_next;
    dir_t        dx, dx_next;
    dir_t        dy, dy_next;
    logic [5:0]  ball_x, ball_x_next;
    logic [5:0]  ball_y, ball_y_next;
    logic        p1_score, p1_score_next;
    logic        p2_score, p2_score_next;
    logic        draw;
    logic        playing;
    logic        step_tick;
    logic        miss_left;
    logic        miss_right;

    assign playing = (state == PLAY);

    pong_tick_gen #(
        .c_TERMINAL(c_BALL_SPEED)
    ) u_tick_gen (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_En   (playing),
        .o_Tick (step_tick)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            dx       <= DIR_POS;
            dy       <= DIR_POS;
            ball_x   <= c_CENTER_X;
            ball_y   <= c_CENTER_Y;
            p1_score <= 1'b0;
            p2_score <= 1'b0;
            draw     <= 1'b0;
        end else begin
            state    <= state_next;
            dx       <= dx_next;
            dy       <= dy_next;
            ball_x   <= ball_x_next;
            ball_y   <= ball_y_next;
            p1_score <= p1_score_next;
            p2_score <= p2_score_next;
            draw     <= (i_Col_Count_Div == ball_x) && (i_Row_Count_Div == ball_y);
        end
    end

    always_comb begin
        state_next    = state;
        dx_next       = dx;
        dy_next       = dy;
        ball_x_next   = ball_x;
        ball_y_next   = ball_y;
        p1_score_next = 1'b0;
        p2_score_next = 1'b0;
        miss_left     = 1'b0;
        miss_right    = 1'b0;

        case (state)
            IDLE: begin
                ball_x_next = c_CENTER_X;
                ball_y_next = c_CENTER_Y;
                if (i_Game_Start) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (step_tick) begin
                    if (dy == DIR_POS) begin
                        if (ball_y == c_Y_MAX) begin
                            dy_next     = DIR_NEG;
                            ball_y_next = ball_y - 6'd1;
                        end else begin
                            ball_y_next = ball_y + 6'd1;
                        end
                    end else begin
                        if (ball_y == '0) begin
                            dy_next     = DIR_POS;
                            ball_y_next = ball_y + 6'd1;
                        end else begin
                            ball_y_next = ball_y - 6'd1;
                        end
                    end

                    if (dx == DIR_NEG) begin
                        if (ball_x == c_LEFT_HIT_X) begin
                            if (in_paddle_range(ball_y, i_P1_Paddle_Y)) begin
                                dx_next     = DIR_POS;
                                ball_x_next = ball_x + 6'd1;
                            end else begin
                                miss_left = 1'b1;
                            end
                        end else begin
                            ball_x_next = ball_x - 6'd1;
                        end
                    end else begin
                        if (ball_x == c_RIGHT_HIT_X) begin
                            if (in_paddle_range(ball_y, i_P2_Paddle_Y)) begin
                                dx_next     = DIR_NEG;
                                ball_x_next = ball_x - 6'd1;
                            end else begin
                                miss_right = 1'b1;
                            end
                        end else begin
                            ball_x_next = ball_x + 6'd1;
                        end
                    end

                    // A miss overrides the step: recenter, serve toward the loser.
                    if (miss_left) begin
                        state_next    = IDLE;
                        ball_x_next   = c_CENTER_X;
                        ball_y_next   = c_CENTER_Y;
                        dx_next       = DIR_NEG;
                        dy_next       = dy;
                        p2_score_next = 1'b1;
                    end else if (miss_right) begin
                        state_next    = IDLE;
                        ball_x_next   = c_CENTER_X;
                        ball_y_next   = c_CENTER_Y;
                        dx_next       = DIR_POS;
                        dy_next       = dy;
                        p1_score_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_Draw_Ball      = draw;
    assign o_Ball_X         = ball_x;
    assign o_Ball_Y         = ball_y;
    assign o_P1_Score_Pulse = p1_score;
    assign o_P2_Score_Pulse = p2_score;
    assign o_Active         = playing;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Self-checking bench for pong_ball_ctrl: fixed draw vectors, a directed rally
// with known bounce/miss points, async reset, then random play against a model.
module tb_pong_ball_ctrl;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int PH    = 6;
    localparam int SPEED = 3;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       start;
    logic [5:0] col;
    logic [5:0] row;
    logic [5:0] p1y;
    logic [5:0] p2y;
    logic       draw;
    logic [5:0] bx;
    logic [5:0] by;
    logic       p1s;
    logic       p2s;
    logic       active;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pong_ball_ctrl #(
        .c_BALL_SPEED(SPEED)
    ) dut (
        .i_Clk           (clk),
        .i_Rst_L         (rst_l),
        .i_Game_Start    (start),
        .i_Col_Count_Div (col),
        .i_Row_Count_Div (row),
        .i_P1_Paddle_Y   (p1y),
        .i_P2_Paddle_Y   (p2y),
        .o_Draw_Ball     (draw),
        .o_Ball_X        (bx),
        .o_Ball_Y        (by),
        .o_P1_Score_Pulse(p1s),
        .o_P2_Score_Pulse(p2s),
        .o_Active        (active)
    );

    // Behavioural model: ball as signed position plus velocity (+1/-1).
    bit m_play;
    int m_cnt, m_x, m_y, m_vx, m_vy;
    bit m_draw, m_p1s, m_p2s;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_play = 0; m_cnt = 0;
        m_x = W / 2; m_y = H / 2;
        m_vx = 1; m_vy = 1;
        m_draw = 0; m_p1s = 0; m_p2s = 0;
    endfunction

    function automatic void model_step();
        int ny, nvy, nx, nvx, hit_col, top;
        bit miss;
        miss = 0;
        nx = m_x; nvx = m_vx;
        ny = m_y + m_vy; nvy = m_vy;
        if (ny < 0 || ny > H - 1) begin
            nvy = -m_vy;
            ny  = m_y - m_vy;
        end
        hit_col = (m_vx < 0) ? 1 : W - 2;
        top     = (m_vx < 0) ? int'(p1y) : int'(p2y);
        if (m_x == hit_col) begin
            if (m_y >= top && m_y <= top + PH) begin
                nvx = -m_vx;
                nx  = m_x - m_vx;
            end else begin
                miss = 1;
            end
        end else begin
            nx = m_x + m_vx;
        end
        if (miss) begin
            // Loser's side keeps the serve direction; vertical direction kept.
            if (m_vx < 0) m_p2s = 1; else m_p1s = 1;
            m_play = 0;
            m_x = W / 2; m_y = H / 2;
        end else begin
            m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy;
        end
    endfunction

    function automatic void model_edge();
        bit nd;
        nd = (int'(col) == m_x) && (int'(row) == m_y);
        m_p1s = 0; m_p2s = 0;
        if (!m_play) begin
            m_cnt = 0;
            if (start) m_play = 1;
        end else if (m_cnt < SPEED) begin
            m_cnt++;
        end else begin
            m_cnt = 0;
            model_step();
        end
        m_draw = nd;
    endfunction

    task automatic compare();
        chk("ball_x", int'(bx), m_x);
        chk("ball_y", int'(by), m_y);
        chk("draw", int'(draw), int'(m_draw));
        chk("p1_pulse", int'(p1s), int'(m_p1s));
        chk("p2_pulse", int'(p2s), int'(m_p2s));
        chk("active", int'(active), int'(m_play));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"}, int'(bx), 20);
        chk({tag, "_y"}, int'(by), 15);
        chk({tag, "_active"}, int'(active), 0);
        chk({tag, "_p1"}, int'(p1s), 0);
        chk({tag, "_p2"}, int'(p2s), 0);
        chk({tag, "_draw"}, int'(draw), 0);
    endtask

    task automatic async_reset_mid();
        @(posedge clk);
        model_edge();
        #2 rst_l = 1'b0;
        model_reset();
        #1 check_reset_values("async_rst");
        @(negedge clk);
        compare();
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    typedef struct {
        logic [5:0] c;
        logic [5:0] r;
        int         exp;
    } draw_vec_t;

    draw_vec_t dv[8];

    initial begin
        dv[0] = '{6'd20, 6'd15, 1};
        dv[1] = '{6'd21, 6'd15, 0};
        dv[2] = '{6'd20, 6'd16, 0};
        dv[3] = '{6'd19, 6'd15, 0};
        dv[4] = '{6'd20, 6'd14, 0};
        dv[5] = '{6'd0,  6'd0,  0};
        dv[6] = '{6'd15, 6'd20, 0};
        dv[7] = '{6'd20, 6'd15, 1};

        rst_l = 1'b1; start = 1'b0; col = 6'd63; row = 6'd63;
        p1y = 6'd0; p2y = 6'd19;
        model_reset();
        #1 rst_l = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;

        // Draw vectors in IDLE: ball sits at (20,15).
        for (int i = 0; i < 8; i++) begin
            col = dv[i].c; row = dv[i].r;
            tick();
            chk("draw_tbl", int'(draw), dv[i].exp);
        end
        col = 6'd63; row = 6'd63;

        // Directed rally: bottom wall at step 15, P2 edge hit (Y=25=19+6) at
        // step 19, top wall at step 44, P1 miss at X=1,Y=12 on step 56.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_active", int'(active), 1);
        for (int e = 1; e <= 230; e++) begin
            if (e == 100) start = 1'b1;
            if (e == 101) start = 1'b0;
            tick();
            if (e == 3)   chk("pre_step_x", int'(bx), 20);
            if (e == 4)   begin chk("step1_x", int'(bx), 21); chk("step1_y", int'(by), 16); end
            if (e == 8)   begin chk("step2_x", int'(bx), 22); chk("step2_y", int'(by), 17); end
            if (e == 60)  begin chk("wall_x", int'(bx), 35); chk("wall_y", int'(by), 28); end
            if (e == 72)  begin chk("at_p2_x", int'(bx), 38); chk("at_p2_y", int'(by), 25); end
            if (e == 76)  begin chk("p2_hit_x", int'(bx), 37); chk("p2_hit_y", int'(by), 24);
                                chk("p2_hit_pulse", int'(p1s), 0); end
            if (e == 176) begin chk("top_x", int'(bx), 12); chk("top_y", int'(by), 1); end
            if (e == 220) begin chk("at_p1_x", int'(bx), 1); chk("at_p1_y", int'(by), 12); end
            if (e == 224) begin chk("miss_pulse", int'(p2s), 1); chk("miss_other", int'(p1s), 0); end
            if (e == 225) begin chk("miss_pulse_end", int'(p2s), 0); chk("miss_idle", int'(active), 0);
                                chk("miss_cx", int'(bx), 20); chk("miss_cy", int'(by), 15); end
        end

        // Next serve heads toward P1 with dy still down.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("serve_left_x", int'(bx), 19);
        chk("serve_left_y", int'(by), 16);
        for (int i = 0; i < 5; i++) tick();
        async_reset_mid();

        // Random play against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                col = 6'(m_x); row = 6'(m_y);
            end else begin
                col = 6'($urandom_range(0, 63)); row = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 15) == 0) p1y = 6'($urandom_range(0, 29));
            if ($urandom_range(0, 15) == 0) p2y = 6'($urandom_range(0, 29));
            if ($urandom_range(0, 199) == 0) begin
                p1y = 6'($urandom_range(30, 63));
                p2y = 6'($urandom_range(30, 63));
            end
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 999) == 0) async_reset_mid();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
